// File: rtl/f1_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : f1_pkg
//  Brief    : Shared state encoding and default widths for the F1 start-light
//             sequencer.
//  Revision : 1.0
// ============================================================================
package f1_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNT_UP = 2'd1,
        HOLD     = 2'd2,
        REACT    = 2'd3
    } f1_state_t;

    localparam int NLIGHTS_DEF = 8;
    localparam int RAND_W_DEF  = 7;
    localparam int REACT_W     = 16;

endpackage
`default_nettype wire

// File: rtl/f1_start_seq_rise_det.sv
`default_nettype none
// ============================================================================
//  Module   : rise_det
//  Brief    : Registers d and flags a combinational rising edge (d & ~d_q).
//  Revision : 1.0
// ============================================================================
module rise_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic r_d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_q <= 1'b0;
        end else begin
            r_d_q <= d;
        end
    end

    assign rise = d & ~r_d_q;

endmodule
`default_nettype wire

// File: rtl/f1_start_seq.sv
`default_nettype none
// ============================================================================
//  Module   : f1_start_seq
//  Brief    : Start-light sequencer: lamps on one per tick, random hold from the
//             LFSR, then all off with a go pulse. Define REACTION_TIMER_EN to add
//             the reaction timer measured from go to the stop rising edge.
//  Revision : 1.0
// ============================================================================
module f1_start_seq
    import f1_pkg::*;
#(
    parameter int NLIGHTS = NLIGHTS_DEF,
    parameter int RAND_W  = RAND_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 trigger,
    input  logic [RAND_W-1:0]    rnd_in,
    output logic                 lfsr_en,
    output logic [NLIGHTS-1:0]   lights,
    output logic                 busy,
    output logic                 go,
    input  logic                 stop,
    output logic [REACT_W-1:0]   react_time,
    output logic                 react_valid
);

    f1_state_t            r_state, w_state_n;
    logic [NLIGHTS-1:0]   r_lights, w_lights_n, w_shifted;
    logic [RAND_W-1:0]    r_dly, w_dly_n;
    logic                 r_go, w_go_n;
    logic                 w_trg_rise;
    logic                 w_stop_done;

    rise_det u_trg_det (
        .clk  (clk),
        .rst  (rst),
        .d    (trigger),
        .rise (w_trg_rise)
    );

    assign w_shifted = {r_lights[NLIGHTS-2:0], 1'b1};

    always_comb begin
        w_state_n  = r_state;
        w_lights_n = r_lights;
        w_dly_n    = r_dly;
        w_go_n     = 1'b0;
        case (r_state)
            IDLE: begin
                w_lights_n = '0;
                if (w_trg_rise) begin
                    w_state_n = COUNT_UP;
                end
            end
            COUNT_UP: begin
                if (tick) begin
                    w_lights_n = w_shifted;
                    // LFSR is frozen outside IDLE, so rnd_in is stable here
                    if (&w_shifted) begin
                        w_dly_n   = (rnd_in == '0) ? RAND_W'(1) : rnd_in;
                        w_state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (r_dly == RAND_W'(1)) begin
                        w_lights_n = '0;
                        w_go_n     = 1'b1;
`ifdef REACTION_TIMER_EN
                        w_state_n  = REACT;
`else
                        w_state_n  = IDLE;
`endif
                    end else begin
                        w_dly_n = r_dly - RAND_W'(1);
                    end
                end
            end
            REACT: begin
                if (w_stop_done) begin
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_lights <= '0;
            r_dly    <= '0;
            r_go     <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_lights <= w_lights_n;
            r_dly    <= w_dly_n;
            r_go     <= w_go_n;
        end
    end

    assign lights  = r_lights;
    assign go      = r_go;
    assign busy    = (r_state != IDLE);
    assign lfsr_en = (r_state == IDLE);

`ifdef REACTION_TIMER_EN
    logic                 w_stop_rise;
    logic [REACT_W-1:0]   r_cnt;
    logic [REACT_W-1:0]   r_react_time;
    logic                 r_react_valid;

    rise_det u_stop_det (
        .clk  (clk),
        .rst  (rst),
        .d    (stop),
        .rise (w_stop_rise)
    );

    // r_cnt is 0 during the go cycle, which is how a stop edge there is ignored
    assign w_stop_done = (r_state == REACT) && w_stop_rise && (r_cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt         <= '0;
            r_react_time  <= '0;
            r_react_valid <= 1'b0;
        end else begin
            r_react_valid <= w_stop_done;
            if (w_go_n) begin
                r_cnt <= '0;
            end else if ((r_state == REACT) && !(&r_cnt)) begin
                r_cnt <= r_cnt + REACT_W'(1);
            end
            if (w_stop_done) begin
                r_react_time <= r_cnt;
            end
        end
    end

    assign react_time  = r_react_time;
    assign react_valid = r_react_valid;
`else
    logic unused_stop;

    assign unused_stop = stop;
    assign w_stop_done = 1'b0;
    assign react_time  = '0;
    assign react_valid = 1'b0;
`endif

endmodule
`default_nettype wire
